// File: rtl/dmem_ctrl.sv
// Data-memory controller: lane enables, store replication, load extension,
// core stall and fault reporting over a variable-latency req/ack memory.
module dmem_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_size,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_misalign,
    output logic        cpu_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic [1:0]  r_off;
    logic [2:0]  r_size;

    logic        w_illegal;
    logic        w_misalign;
    logic        w_accept;
    logic        w_sgn;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_bsh;
    logic [31:0] w_hsh;
    logic [31:0] w_ext;

    // Size legality: unsigned variants exist only for loads
    always_comb begin
        w_illegal = 1'b1;
        case (cpu_size)
            3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
            3'b100, 3'b101:         w_illegal = cpu_we;
            default:                w_illegal = 1'b1;
        endcase
    end

    assign w_misalign = ((cpu_size[1:0] == 2'b01) && cpu_addr[0]) ||
                        ((cpu_size[1:0] == 2'b10) && (cpu_addr[1:0] != 2'b00));

    assign w_accept = (r_state == S_IDLE) && cpu_en && !w_illegal && !w_misalign;

    // Stall is held low while reset is asserted so every output reads zero
    assign cpu_stall = !rst && (w_accept || (r_state == S_REQ));

    // Byte-lane enables and store-data replication for the request
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = cpu_wdata;
        case (cpu_size[1:0])
            2'b00: begin
                w_be    = 4'b0001 << cpu_addr[1:0];
                w_wdata = {4{cpu_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {cpu_addr[1], 1'b0};
                w_wdata = {2{cpu_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = cpu_wdata;
            end
        endcase
    end

    assign w_sgn = ~r_size[2];
    assign w_bsh = mem_rdata >> {r_off, 3'b000};
    assign w_hsh = mem_rdata >> {r_off[1], 4'b0000};

    // Lane extraction and sign/zero extension of the returned word
    always_comb begin
        w_ext = '0;
        case (r_size[1:0])
            2'b00:   w_ext = {{24{w_sgn & w_bsh[7]}}, w_bsh[7:0]};
            2'b01:   w_ext = {{16{w_sgn & w_hsh[15]}}, w_hsh[15:0]};
            2'b10:   w_ext = mem_rdata;
            default: w_ext = '0;
        endcase
    end

    // Access FSM with registered memory-side and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_off        <= '0;
            r_size       <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            cpu_rdata    <= '0;
            cpu_misalign <= 1'b0;
            cpu_fault    <= 1'b0;
        end else begin
            cpu_misalign <= 1'b0;
            cpu_fault    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (cpu_en) begin
                        if (w_illegal) begin
                            cpu_fault <= 1'b1;
                        end else if (w_misalign) begin
                            cpu_misalign <= 1'b1;
                        end else begin
                            r_we      <= cpu_we;
                            r_off     <= cpu_addr[1:0];
                            r_size    <= cpu_size;
                            mem_req   <= 1'b1;
                            mem_we    <= cpu_we;
                            mem_addr  <= {cpu_addr[31:2], 2'b00};
                            mem_wdata <= w_wdata;
                            mem_be    <= w_be;
                            r_state   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        cpu_rdata <= r_we ? 32'd0 : w_ext;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        r_state   <= S_DONE;
                    end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                        cpu_rdata <= '0;
                        cpu_fault <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed vector bench for dmem_ctrl: access table plus reset-in-flight
// sequence, checking latency, lanes, extension and fault pulses.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [2:0]  cpu_size;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_misalign;
    logic        cpu_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_en       (cpu_en),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_size     (cpu_size),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .cpu_misalign (cpu_misalign),
        .cpu_fault    (cpu_fault),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_dly;
        logic [31:0] rdata;
        int          x_stall;
        int          x_req;
        logic [3:0]  x_be;
        logic [31:0] x_wdata;
        logic [31:0] x_rdata;
        logic        x_mis;
        logic        x_flt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic we, logic [2:0] sz, logic [31:0] a,
                                logic [31:0] wd, int dly, logic [31:0] rd,
                                int xs, int xr, logic [3:0] xbe,
                                logic [31:0] xwd, logic [31:0] xrd,
                                logic xm, logic xf);
        vec_t v;
        v.we = we; v.size = sz; v.addr = a; v.wdata = wd;
        v.ack_dly = dly; v.rdata = rd;
        v.x_stall = xs; v.x_req = xr; v.x_be = xbe;
        v.x_wdata = xwd; v.x_rdata = xrd; v.x_mis = xm; v.x_flt = xf;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic do_vec(int idx, vec_t v);
        int          n_stall;
        int          n_req;
        logic        saw_mis;
        logic        done;
        logic        unstable;
        logic [31:0] c_addr;
        logic [31:0] c_wdata;
        logic [3:0]  c_be;
        logic        c_we;
        logic [31:0] d_rdata;
        logic        d_flt;
        string       p;
        p = $sformatf("v%0d", idx);
        n_stall = 0; n_req = 0; saw_mis = 1'b0; done = 1'b0;
        unstable = 1'b0;
        c_addr = '0; c_wdata = '0; c_be = '0; c_we = 1'b0;
        d_rdata = '0; d_flt = 1'b0;
        @(posedge clk); #1;
        cpu_en = 1'b1; cpu_we = v.we; cpu_addr = v.addr;
        cpu_wdata = v.wdata; cpu_size = v.size; mem_ack = 1'b0;
        @(negedge clk);
        if (!cpu_stall) begin
            chk({p, "_stall"}, 32'(n_stall), 32'(v.x_stall));
            @(posedge clk); #1;
            cpu_en = 1'b0;
            @(negedge clk);
            chk({p, "_mis"}, 32'(cpu_misalign), 32'(v.x_mis));
            chk({p, "_flt"}, 32'(cpu_fault), 32'(v.x_flt));
            chk({p, "_req"}, 32'(mem_req), 32'(v.x_req > 0));
            @(negedge clk);
            chk({p, "_pulse_end"}, 32'(cpu_misalign | cpu_fault), 32'd0);
            chk({p, "_req_end"}, 32'(mem_req), 32'd0);
        end else begin
            n_stall = 1;
            for (int c = 1; c < 40 && !done; c++) begin
                @(negedge clk);
                if (cpu_misalign) saw_mis = 1'b1;
                if (!cpu_stall) begin
                    done = 1'b1;
                    d_rdata = cpu_rdata;
                    d_flt = cpu_fault;
                    mem_ack = 1'b0;
                end else begin
                    n_stall++;
                    if (mem_req) begin
                        if (n_req == 0) begin
                            c_addr = mem_addr; c_wdata = mem_wdata;
                            c_be = mem_be; c_we = mem_we;
                        end else if (mem_addr !== c_addr || mem_be !== c_be ||
                                     mem_wdata !== c_wdata || mem_we !== c_we) begin
                            unstable = 1'b1;
                        end
                        if (n_req == v.ack_dly) begin
                            mem_ack = 1'b1; mem_rdata = v.rdata;
                        end else begin
                            mem_ack = 1'b0; mem_rdata = 32'hBAD0BAD0;
                        end
                        n_req++;
                    end else begin
                        mem_ack = 1'b0;
                    end
                end
            end
            chk({p, "_finished"}, 32'(done), 32'd1);
            chk({p, "_stall"}, 32'(n_stall), 32'(v.x_stall));
            chk({p, "_req"}, 32'(n_req), 32'(v.x_req));
            chk({p, "_addr"}, c_addr, {v.addr[31:2], 2'b00});
            chk({p, "_be"}, 32'(c_be), 32'(v.x_be));
            chk({p, "_wdata"}, c_wdata, v.x_wdata);
            chk({p, "_we"}, 32'(c_we), 32'(v.we));
            chk({p, "_stable"}, 32'(unstable), 32'd0);
            chk({p, "_rdata"}, d_rdata, v.x_rdata);
            chk({p, "_flt"}, 32'(d_flt), 32'(v.x_flt));
            chk({p, "_mis"}, 32'(saw_mis), 32'(v.x_mis));
            @(posedge clk); #1;
            cpu_en = 1'b0;
            @(negedge clk);
            chk({p, "_idle_req"}, 32'(mem_req), 32'd0);
            chk({p, "_idle_flt"}, 32'(cpu_fault), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; cpu_en = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
        cpu_wdata = '0; cpu_size = '0; mem_ack = 1'b0; mem_rdata = '0;

        //        we  size    addr         wdata       dly  rdata       st  rq  be       wdata_x      rdata_x      m  f
        tbl.push_back(mk(0, 3'b010, 32'h100, 32'h12345678, 2, 32'hDEADBEEF, 4, 3, 4'b1111, 32'h12345678, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(1, 3'b000, 32'h103, 32'h000000A5, 0, 32'hFFFFFFFF, 2, 1, 4'b1000, 32'hA5A5A5A5, 32'h00000000, 0, 0));
        tbl.push_back(mk(0, 3'b000, 32'h102, 32'h11223344, 0, 32'h00807F00, 2, 1, 4'b0100, 32'h44444444, 32'hFFFFFF80, 0, 0));
        tbl.push_back(mk(0, 3'b100, 32'h102, 32'h11223344, 0, 32'h00807F00, 2, 1, 4'b0100, 32'h44444444, 32'h00000080, 0, 0));
        tbl.push_back(mk(0, 3'b101, 32'h102, 32'h11223344, 0, 32'h80007F00, 2, 1, 4'b1100, 32'h33443344, 32'h00008000, 0, 0));
        tbl.push_back(mk(0, 3'b001, 32'h102, 32'h11223344, 1, 32'h80007F00, 3, 2, 4'b1100, 32'h33443344, 32'hFFFF8000, 0, 0));
        tbl.push_back(mk(0, 3'b001, 32'h100, 32'h00000000, 0, 32'h80007F00, 2, 1, 4'b0011, 32'h00000000, 32'h00007F00, 0, 0));
        tbl.push_back(mk(1, 3'b001, 32'h106, 32'hCAFEBEEF, 0, 32'h00000000, 2, 1, 4'b1100, 32'hBEEFBEEF, 32'h00000000, 0, 0));
        tbl.push_back(mk(1, 3'b010, 32'h208, 32'h01020304, 0, 32'h00000000, 2, 1, 4'b1111, 32'h01020304, 32'h00000000, 0, 0));
        tbl.push_back(mk(0, 3'b000, 32'h101, 32'h00000000, 0, 32'h0000FF00, 2, 1, 4'b0010, 32'h00000000, 32'hFFFFFFFF, 0, 0));
        tbl.push_back(mk(0, 3'b000, 32'h103, 32'h00000000, 0, 32'h7F000000, 2, 1, 4'b1000, 32'h00000000, 32'h0000007F, 0, 0));
        tbl.push_back(mk(0, 3'b010, 32'h101, 32'h00000000, 0, 32'h00000000, 0, 0, 4'b0000, 32'h00000000, 32'h00000000, 1, 0));
        tbl.push_back(mk(1, 3'b010, 32'h102, 32'h00000000, 0, 32'h00000000, 0, 0, 4'b0000, 32'h00000000, 32'h00000000, 1, 0));
        tbl.push_back(mk(0, 3'b001, 32'h103, 32'h00000000, 0, 32'h00000000, 0, 0, 4'b0000, 32'h00000000, 32'h00000000, 1, 0));
        tbl.push_back(mk(0, 3'b101, 32'h101, 32'h00000000, 0, 32'h00000000, 0, 0, 4'b0000, 32'h00000000, 32'h00000000, 1, 0));
        tbl.push_back(mk(0, 3'b011, 32'h100, 32'h00000000, 0, 32'h00000000, 0, 0, 4'b0000, 32'h00000000, 32'h00000000, 0, 1));
        tbl.push_back(mk(1, 3'b100, 32'h100, 32'h00000000, 0, 32'h00000000, 0, 0, 4'b0000, 32'h00000000, 32'h00000000, 0, 1));
        tbl.push_back(mk(0, 3'b110, 32'h100, 32'h00000000, 0, 32'h00000000, 0, 0, 4'b0000, 32'h00000000, 32'h00000000, 0, 1));
        tbl.push_back(mk(0, 3'b010, 32'h10C, 32'h00000000, -1, 32'h00000000, 16, 15, 4'b1111, 32'h00000000, 32'h00000000, 0, 1));
        tbl.push_back(mk(0, 3'b010, 32'h110, 32'h00000000, 14, 32'h13579BDF, 16, 15, 4'b1111, 32'h00000000, 32'h13579BDF, 0, 0));

        repeat (2) @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[i]) do_vec(i, tbl[i]);

        // Reset while a request is outstanding, then a stray late ack
        @(posedge clk); #1;
        cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300;
        cpu_size = 3'b010; cpu_wdata = 32'h0F0F0F0F; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rr_pre_req", 32'(mem_req), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rr_req", 32'(mem_req), 32'd0);
        chk("rr_addr", mem_addr, 32'd0);
        chk("rr_wdata", mem_wdata, 32'd0);
        chk("rr_be", 32'(mem_be), 32'd0);
        chk("rr_rdata", cpu_rdata, 32'd0);
        chk("rr_stall", 32'(cpu_stall), 32'd0);
        chk("rr_flags", 32'({cpu_fault, cpu_misalign, mem_we}), 32'd0);
        cpu_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h00000055;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rr_ack_req", 32'(mem_req), 32'd0);
        chk("rr_ack_rdata", cpu_rdata, 32'd0);
        chk("rr_ack_stall", 32'(cpu_stall), 32'd0);
        @(negedge clk);
        chk("rr_ack_req2", 32'(mem_req), 32'd0);
        do_vec(99, mk(0, 3'b010, 32'h300, 32'h0F0F0F0F, 0, 32'hCAFEF00D,
                      2, 1, 4'b1111, 32'h0F0F0F0F, 32'hCAFEF00D, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller sitting directly downstream of the CPU core's data port. Consumes datamem_en/datamem_we, ALU result (address) and rs2 (store data); drives a variable-latency word-wide memory over a req/ack handshake.
- Generates byte-lane enables and store-data replication, performs load extraction and sign/zero extension, and stalls the core until each access completes.
- Flags misaligned and illegal-size accesses, and memory timeouts.

Parameters:
- TIMEOUT, 15: max cycles in REQ without mem_ack before the access is aborted with a fault (range 1..255).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_en  in  1  access request (core datamem_en)
- cpu_we  in  1  1=store, 0=load (core datamem_we)
- cpu_addr  in  32  byte address (core ALU result)
- cpu_wdata  in  32  store data (core rs2)
- cpu_size  in  3  funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- cpu_rdata  out  32  extended load data, valid in DONE
- cpu_stall  out  1  core must hold its pipeline
- cpu_misalign  out  1  one-cycle pulse: misaligned access rejected
- cpu_fault  out  1  one-cycle pulse: illegal size or timeout
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  32  word address, {cpu_addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ack  in  1  memory completion, one-cycle pulse
- mem_rdata  in  32  read word, valid with mem_ack

Behaviour:
- Reset (async, any state): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, cpu_rdata=0, cpu_misalign=0, cpu_fault=0, timeout counter=0. An ack arriving after reset is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE, cpu_en=0: nothing; cpu_stall=0.
- IDLE, cpu_en=1, illegal cpu_size (011, 110, 111, or 100/101 with cpu_we=1): cpu_fault pulses next cycle; no memory access; stay IDLE; cpu_stall=0.
- IDLE, cpu_en=1, misaligned (halfword with addr[0]=1; word with addr[1:0]!=0): cpu_misalign pulses next cycle; no memory access; stay IDLE; cpu_stall=0.
- IDLE, cpu_en=1, legal and aligned: cpu_stall=1 combinationally; latch we, addr[1:0], size; register mem_* outputs; go to REQ.
- REQ: mem_req=1, cpu_stall=1; mem_* stable until ack.
  - mem_ack=1: capture the extended load (stores give cpu_rdata=0); drop mem_req next cycle; go to DONE.
  - No ack: counter increments. When counter==TIMEOUT-1 without ack: drop mem_req; cpu_rdata=0; cpu_fault pulses in DONE; go to DONE. Ack and timeout in the same cycle: ack wins.
- DONE: cpu_stall=0, cpu_rdata valid, mem_req=0; always return to IDLE. cpu_en is ignored in DONE because it is the same instruction retiring. Counter cleared.
- Minimum access latency is 3 cycles: accept, REQ with immediate ack, DONE.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111. Loads use the same be.
- Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word unchanged.
- Load extraction: byte = mem_rdata>>(8*addr[1:0]); half = mem_rdata>>(16*addr[1]). LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.

Test Plan:
- LW addr 0x100, mem_ack 2 cycles after mem_req, mem_rdata 0xDEADBEEF -> mem_addr 0x100, be 1111, stall high 4 cycles, cpu_rdata 0xDEADBEEF in DONE.
- SB addr 0x103, wdata 0x000000A5, immediate ack -> mem_we=1, be 1000, mem_wdata 0xA5A5A5A5, 3-cycle access.
- LB addr 0x102, mem_rdata 0x00807F00 -> 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102, mem_rdata 0x80007F00 -> 0x00008000.
- LW addr 0x101 -> cpu_misalign one-cycle pulse, mem_req never asserted, stall 0; cpu_size 011 -> cpu_fault pulse, no request.
- TIMEOUT=15, no ack -> mem_req high exactly 15 cycles, then DONE with cpu_fault=1 and cpu_rdata 0; an ack landing on cycle 15 -> normal completion, no fault.
- rst asserted during REQ, then a late mem_ack -> all outputs zero immediately; ack ignored; next LW completes normally.
